// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX training and statistics signals of the branch predictor
interface branch_predictor_if #(parameter int XLEN = 32);
  logic            if_pc_valid_unused;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            ex_mispredict;
  logic            flush_all;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, flush_all,
    input  pred_taken, pred_target, ex_mispredict, stat_branches, stat_mispredicts
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, flush_all,
    output pred_taken, pred_target, ex_mispredict, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT+BTB with saturating counters, mispredict flag and statistics
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [31:0]        stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
  logic [IDX_W-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic               f_hit, e_hit, unused_pc;
  assign f_idx = bus.if_pc[IDX_W+1:2];
  assign f_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign e_idx = bus.ex_pc[IDX_W+1:2];
  assign e_tag = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{bus.if_pc, bus.ex_pc};
  assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
  assign e_hit = valid_q[e_idx] && tag_q[e_idx] == e_tag;
  assign bus.pred_taken       = f_hit && ctr_q[f_idx][CTR_W-1];
  assign bus.pred_target      = bus.pred_taken ? target_q[f_idx] : bus.if_pc + XLEN'(4);
  assign bus.ex_mispredict    = bus.ex_valid && (bus.ex_taken != bus.ex_pred_taken ||
                                (bus.ex_taken && bus.ex_pred_target != bus.ex_target));
  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    stat_br_d = stat_br_q + 32'(bus.ex_valid && stat_br_q != '1);
    stat_mp_d = stat_mp_q + 32'(bus.ex_mispredict && stat_mp_q != '1);
    // a flush wins over training in the same cycle
    if (bus.flush_all) valid_d = '0;
    else if (bus.ex_valid && e_hit) begin
      ctr_d[e_idx] = bus.ex_taken ? ctr_q[e_idx] + CTR_W'(ctr_q[e_idx] != '1)
                                  : ctr_q[e_idx] - CTR_W'(ctr_q[e_idx] != '0);
      if (bus.ex_taken) target_d[e_idx] = bus.ex_target;
    end else if (bus.ex_valid && bus.ex_taken) begin
      valid_d[e_idx]  = 1'b1;
      tag_d[e_idx]    = e_tag;
      target_d[e_idx] = bus.ex_target;
      ctr_d[e_idx]    = CTR_WT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      tag_q     <= '{default: '0};
      target_q  <= '{default: '0};
      ctr_q     <= '{default: CTR_WNT};
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end
endmodule
